// File: rtl/ins_loader.sv
// rtl/ins_loader.sv - framed byte-stream loader that fills instruction memory and releases the pipeline
// Frame: LEN_HI, LEN_LO, 4*N big-endian word bytes, XOR checksum of all preceding bytes.
module ins_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        run,
  output logic        error,
  output logic        busy
);

  localparam int WIDX = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_SUM, S_DONE, S_ERR} state_t;

  state_t          state, state_nxt;
  logic [15:0]     len;
  logic [7:0]      xor_acc;
  logic [WIDX-1:0] word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic            accept;
  logic [15:0]     len_full;
  logic            last_word;

  assign in_ready  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_SUM);
  assign accept    = in_valid && in_ready && !restart;
  assign len_full  = {len[15:8], in_data};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LEN0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    run       = 1'b0;
    error     = 1'b0;
    case (state)
      S_LEN0: if (in_valid) state_nxt = S_LEN1;
      S_LEN1: begin
        busy = 1'b1;
        if (in_valid) begin
          if ({16'd0, len_full} > 32'(DEPTH)) state_nxt = S_ERR;
          else if (len_full == 16'd0)          state_nxt = S_SUM;
          else                                 state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (in_valid && byte_idx == 2'd3 && last_word) state_nxt = S_SUM;
      end
      S_SUM: begin
        busy = 1'b1;
        if (in_valid) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
      end
      S_DONE:  run       = 1'b1;
      S_ERR:   error     = 1'b1;
      default: state_nxt = S_LEN0;
    endcase
    // restart wins over any byte presented in the same cycle
    if (restart) state_nxt = S_LEN0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      xor_acc  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        len      <= '0;
        xor_acc  <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        asm_q    <= '0;
      end else if (accept) begin
        xor_acc <= xor_acc ^ in_data;
        case (state)
          S_LEN0: begin
            len[15:8] <= in_data;
            len[7:0]  <= '0;
            xor_acc   <= in_data;
          end
          S_LEN1: begin
            len[7:0] <= in_data;
            word_idx <= '0;
            byte_idx <= '0;
          end
          S_DATA: begin
            asm_q    <= {asm_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            // first three bytes of the word sit in asm_q; the fourth completes it
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {asm_q, in_data};
              wr_addr  <= BASE_ADDR + (32'(word_idx) << 2);
              word_idx <= word_idx + WIDX'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// tb/tb_ins_loader.sv - randomized self-checking bench for ins_loader against a frame-level model
module tb_ins_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        restart  = 1'b0;
  logic        in_ready, wr_en, run, error, busy;
  logic [31:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ins_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the bytes accepted in the current frame decide every output.
  logic [7:0]  frame[$];
  bit          pend_acc  = 1'b0;
  bit          pend_rst  = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  logic [31:0] last_addr = BASE;
  int          first_cyc = 0;
  int          log_cyc[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  function automatic int frame_n();
    if (frame.size() >= 2) return int'({frame[0], frame[1]});
    return 0;
  endfunction

  always @(negedge clk) begin
    bit          exp_wr, done, err, bsy;
    logic [31:0] exp_a, exp_d;
    logic [7:0]  xs;
    int          c, n;
    cyc++;
    exp_wr = 1'b0;
    exp_a  = last_addr;
    exp_d  = '0;
    if (!rst_n) begin
      frame.delete();
      last_addr = BASE;
    end else if (pend_rst) begin
      frame.delete();
    end else if (pend_acc) begin
      frame.push_back(pend_byte);
      c = frame.size();
      if (c == 1) first_cyc = cyc - 1;
      n = frame_n();
      if (c >= 6 && (c - 2) % 4 == 0 && n <= DEPTH && c <= 2 + 4 * n) begin
        exp_wr = 1'b1;
        exp_d  = {frame[c-4], frame[c-3], frame[c-2], frame[c-1]};
        exp_a  = BASE + 32'(4 * ((c - 6) / 4));
      end
    end
    c = frame.size();
    n = frame_n();
    done = 1'b0; err = 1'b0; bsy = 1'b0;
    if (c == 1) bsy = 1'b1;
    else if (c >= 2) begin
      if (n > DEPTH) err = 1'b1;
      else if (c < 4 * n + 3) bsy = 1'b1;
      else begin
        xs = 8'h00;
        for (int i = 0; i < 4 * n + 3; i++) xs ^= frame[i];
        if (xs == 8'h00) done = 1'b1;
        else err = 1'b1;
      end
    end
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_data", wr_data, exp_d);
      last_addr = exp_a;
    end
    chk("wr_addr", wr_addr, last_addr);
    chk("run", 32'(run), 32'(done));
    chk("error", 32'(error), 32'(err));
    chk("busy", 32'(busy), 32'(bsy));
    chk("in_ready", 32'(in_ready), 32'(!(done || err)));
    if (wr_en) begin
      log_cyc.push_back(cyc - first_cyc + 1);
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
    pend_rst  = restart;
    pend_acc  = rst_n && in_valid && in_ready && !restart;
    pend_byte = in_data;
  end

  logic [7:0] tx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t == 100) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: in_ready stayed %0b for byte %h", in_ready, b);
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int max_gap);
    for (int i = from; i < to; i++) send_byte(tx[i], max_gap);
  endtask

  task automatic build(input int n);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] l;
    l = 16'(n);
    tx.delete();
    tx.push_back(l[15:8]);
    tx.push_back(l[7:0]);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 3; k >= 0; k--) tx.push_back(w[8*k +: 8]);
    end
    x = 8'h00;
    foreach (tx[i]) x ^= tx[i];
    tx.push_back(x);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
  endtask

  task automatic check_directed(input string tag);
    chk({tag, "_nwr"}, 32'(log_cyc.size()), 32'd2);
    if (log_cyc.size() >= 2) begin
      chk({tag, "_a0"}, log_addr[0], 32'h0000_0000);
      chk({tag, "_d0"}, log_data[0], 32'h2002_0005);
      chk({tag, "_a1"}, log_addr[1], 32'h0000_0004);
      chk({tag, "_d1"}, log_data[1], 32'hAC02_0004);
    end
    chk({tag, "_run"}, 32'(run), 32'd1);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", wr_addr, BASE);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed frame, checksum worked by hand: 00^02^20^02^00^05^AC^02^00^04 = 8F
    tx = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h04, 8'h8F};
    clear_log();
    send_range(0, 11, 0);
    check_directed("dir");
    if (log_cyc.size() >= 2) begin
      chk("dir_cyc0", 32'(log_cyc[0]), 32'd7);
      chk("dir_cyc1", 32'(log_cyc[1]), 32'd11);
    end

    do_restart();
    chk("restart_run", 32'(run), 32'd0);
    clear_log();
    send_range(0, 11, 3);
    check_directed("gap");

    do_restart();
    clear_log();
    tx = '{8'h00, 8'h00, 8'h00};
    send_range(0, 3, 1);
    chk("n0_nwr", 32'(log_cyc.size()), 32'd0);
    chk("n0_run", 32'(run), 32'd1);
    do_restart();
    tx = '{8'h00, 8'h00, 8'h01};
    send_range(0, 3, 0);
    chk("n0bad_err", 32'(error), 32'd1);
    chk("n0bad_run", 32'(run), 32'd0);

    do_restart();
    clear_log();
    tx = '{8'h01, 8'h01};
    send_range(0, 2, 0);
    chk("ovf_err", 32'(error), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("ovf_nwr", 32'(log_cyc.size()), 32'd0);

    do_restart();
    clear_log();
    build(3);
    tx[7] = tx[7] ^ 8'h10;
    send_range(0, tx.size(), 2);
    chk("corrupt_nwr", 32'(log_cyc.size()), 32'd3);
    chk("corrupt_err", 32'(error), 32'd1);
    chk("corrupt_run", 32'(run), 32'd0);
    do_restart();
    chk("recover_err", 32'(error), 32'd0);
    chk("recover_ready", 32'(in_ready), 32'd1);
    build(2);
    send_range(0, tx.size(), 1);
    chk("recover_run", 32'(run), 32'd1);

    // Reset after two bytes of word 1
    do_restart();
    build(3);
    send_range(0, 8, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_addr", wr_addr, BASE);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_run", 32'(run), 32'd0);
    rst_n = 1'b1;
    tick();
    clear_log();
    build(2);
    send_range(0, tx.size(), 0);
    chk("postrst_nwr", 32'(log_cyc.size()), 32'd2);
    if (log_addr.size() >= 1) chk("postrst_a0", log_addr[0], BASE);
    chk("postrst_run", 32'(run), 32'd1);

    // Restart coinciding with the fourth byte of a word
    do_restart();
    clear_log();
    build(2);
    send_range(0, 5, 0);
    in_valid = 1'b1;
    in_data  = tx[5];
    restart  = 1'b1;
    tick();
    restart  = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rstacc_nwr", 32'(log_cyc.size()), 32'd0);
    chk("rstacc_busy", 32'(busy), 32'd0);
    chk("rstacc_ready", 32'(in_ready), 32'd1);
    build(2);
    send_range(0, tx.size(), 0);
    if (log_addr.size() >= 1) chk("rstacc_a0", log_addr[0], BASE);
    chk("rstacc_run", 32'(run), 32'd1);

    // Full-capacity frame
    do_restart();
    clear_log();
    build(DEPTH);
    send_range(0, tx.size(), 0);
    chk("full_nwr", 32'(log_cyc.size()), 32'(DEPTH));
    if (log_addr.size() == DEPTH) chk("full_last_addr", log_addr[DEPTH-1], BASE + 32'(4 * (DEPTH - 1)));
    chk("full_run", 32'(run), 32'd1);

    for (int f = 0; f < 24; f++) begin
      do_restart();
      if ($urandom_range(5, 0) == 0) begin
        tx = '{8'h01, 8'($urandom_range(255, 2))};
        send_range(0, 2, 2);
      end else begin
        build(int'($urandom_range(6, 1)));
        if ($urandom_range(2, 0) == 0) tx[$urandom_range(tx.size() - 1, 2)] ^= 8'(1 << $urandom_range(7, 0));
        send_range(0, tx.size(), int'($urandom_range(3, 0)));
      end
      repeat (2) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
